// File: rtl/div_ctrl.sv
// Sequencer and datapath for the iterative DIV/DIVU unit in EX: one restoring
// step per cycle. It stalls the pipeline while busy and pulses result_valid with HI/LO.
module div_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              div_start,
   input  logic              div_signed,
   input  logic              div_annul,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              div_stall,
   output logic              result_valid,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quot;
   logic [DATA_W-1:0] dvs;
   logic              q_neg;
   logic              r_neg;

   logic              accept;
   logic              last_iter;
   logic [DATA_W-1:0] opa_abs;
   logic [DATA_W-1:0] opb_abs;
   logic [DATA_W:0]   trial;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] rem_nx;
   logic [DATA_W-1:0] quot_nx;

   assign accept    = (state == IDLE) && div_start && !div_annul;
   assign last_iter = (cnt == CNT_W'(DATA_W - 1));
   assign opa_abs   = (div_signed && opa[DATA_W-1]) ? -opa : opa;
   assign opb_abs   = (div_signed && opb[DATA_W-1]) ? -opb : opb;

   // quot doubles as the dividend shift register: its MSB feeds the remainder
   // while the new quotient bit enters at the LSB.
   assign trial   = {rem, quot[DATA_W-1]};
   assign diff    = trial - {1'b0, dvs};
   assign rem_nx  = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
   assign quot_nx = {quot[DATA_W-2:0], ~diff[DATA_W]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // The stall is gated by resetn so a held pipeline is released during reset.
   always_comb begin
      state_nx     = state;
      div_stall    = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            if (div_start && !div_annul) begin
               div_stall = resetn;
               state_nx  = (opb == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (div_annul) begin
               state_nx = IDLE;
            end else begin
               div_stall = resetn;
               if (last_iter) state_nx = DONE;
            end
         end
         DONE: begin
            result_valid = !div_annul;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         rem   <= '0;
         quot  <= '0;
         dvs   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else if (accept) begin
         if (opb == '0) begin
            lo <= '1;
            hi <= opa;
         end else begin
            cnt   <= '0;
            rem   <= '0;
            quot  <= opa_abs;
            dvs   <= opb_abs;
            q_neg <= div_signed && (opa[DATA_W-1] ^ opb[DATA_W-1]);
            r_neg <= div_signed && opa[DATA_W-1];
         end
      end else if (state == BUSY && !div_annul) begin
         cnt  <= cnt + CNT_W'(1);
         rem  <= rem_nx;
         quot <= quot_nx;
         // Sign fixup is folded into the final step so hi/lo are ready in DONE.
         if (last_iter) begin
            lo <= q_neg ? -quot_nx : quot_nx;
            hi <= r_neg ? -rem_nx : rem_nx;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed vector table, abort/reset sequences and random
// divides compared against an arithmetic model of signed/unsigned division.
module tb_div_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         div_start = 1'b0;
   logic         div_signed = 1'b0;
   logic         div_annul = 1'b0;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         div_stall;
   logic         result_valid;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_lo_q = '0;
   logic [W-1:0] exp_hi_q = '0;

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      int           st;
   } vec_t;

   vec_t tbl[8];

   div_ctrl #(.DATA_W(W), .CNT_W(5)) dut (
      .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
      .div_annul(div_annul), .opa(opa), .opb(opb), .div_stall(div_stall),
      .result_valid(result_valid), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Division as defined for DIV/DIVU: magnitudes divided, quotient negative when
   // operand signs differ, remainder takes the dividend sign; /0 gives all ones and raw opa.
   function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      logic [W-1:0] ma, mb, q0, r0;
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         ma = (sgn && a[W-1]) ? (~a + 1) : a;
         mb = (sgn && b[W-1]) ? (~b + 1) : b;
         q0 = ma / mb;
         r0 = ma % mb;
         q  = (sgn && (a[W-1] ^ b[W-1])) ? (~q0 + 1) : q0;
         r  = (sgn && a[W-1]) ? (~r0 + 1) : r0;
      end
   endfunction

   task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input int est);
      int st = 0;
      int cyc = 0;
      bit got = 0;
      @(negedge clk);
      div_start = 1'b1; div_signed = sgn; opa = a; opb = b; div_annul = 1'b0;
      while (!got && cyc < 80) begin
         #1;
         if (result_valid) begin
            got = 1;
            check("done_stall", W'(div_stall), '0);
            check("lo", lo, elo);
            check("hi", hi, ehi);
         end else begin
            if (div_stall) st++;
            @(negedge clk);
            cyc++;
            opa = $urandom;
            opb = $urandom;
         end
      end
      check("result_valid_seen", W'(got), W'(1));
      check("stall_cycles", W'(st), W'(est));
      exp_lo_q = elo;
      exp_hi_q = ehi;
   endtask

   task automatic idle_check(input int n, input bit hold);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            div_start = 1'b0; div_annul = 1'b0;
         end
         #1;
         check("idle_valid", W'(result_valid), '0);
         check("idle_stall", W'(div_stall), '0);
         if (hold) begin
            check("hold_lo", lo, exp_lo_q);
            check("hold_hi", hi, exp_hi_q);
         end
      end
   endtask

   task automatic abort_at(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; opa = a; opb = b; div_annul = 1'b0;
      repeat (k) @(negedge clk);
      div_annul = 1'b1;
      #1;
      check("annul_stall", W'(div_stall), '0);
      check("annul_valid", W'(result_valid), '0);
   endtask

   initial begin
      logic [W-1:0] q, r, a, b;
      logic         sgn;

      tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      tbl[2] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
      tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
      tbl[5] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1};
      tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1};
      tbl[7] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};

      // reset state
      #12;
      check("rst_stall", W'(div_stall), '0);
      check("rst_valid", W'(result_valid), '0);
      check("rst_lo", lo, '0);
      check("rst_hi", hi, '0);
      @(negedge clk);
      resetn = 1'b1;
      idle_check(2, 1);

      for (int i = 0; i < 8; i++) begin
         do_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].st);
         idle_check(1, 1);
      end

      // back-to-back: next request already present the cycle after DONE
      do_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);
      do_div(1'b0, 32'd17, 32'd5, 32'd3, 32'd2, 33);
      do_div(1'b0, 32'd8, 32'd0, 32'hFFFF_FFFF, 32'd8, 1);
      idle_check(1, 1);

      // annul in BUSY cycle 10: no result, hi/lo untouched, then a clean divide
      abort_at(32'd50, 32'd5, 10);
      idle_check(40, 1);
      do_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);
      idle_check(1, 1);

      // annul during DONE suppresses the pulse
      abort_at(32'd20, 32'd3, 33);
      idle_check(3, 0);

      // reset in BUSY cycle 20
      do_div(1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 33);
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; opa = 32'd1000; opb = 32'd3; div_annul = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("busy_stall", W'(div_stall), W'(1));
      resetn = 1'b0;
      #1;
      check("areset_stall", W'(div_stall), '0);
      check("areset_valid", W'(result_valid), '0);
      check("areset_lo", lo, '0);
      check("areset_hi", hi, '0);
      @(negedge clk);
      div_start = 1'b0;
      resetn = 1'b1;
      exp_lo_q = '0;
      exp_hi_q = '0;
      idle_check(40, 1);

      // random operands against the model
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            2: b = -W'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         model(sgn, a, b, q, r);
         do_div(sgn, a, b, q, r, (b == '0) ? 1 : 33);
         if ($urandom_range(0, 1) == 1) idle_check(1, 1);
      end

      idle_check(1, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer for the iterative 32-bit integer divider behind DIV/DIVU in the EX stage. Accepts a divide request from EX and runs a one-bit-per-cycle restoring divide. Holds the pipeline through `div_stall`, which the hazard unit uses to stall F/D/E/M/W. Delivers quotient/remainder to the HI/LO write path with a one-cycle valid pulse.

Parameters:
DATA_W, 32, operand/result width
CNT_W, 5, iteration counter width (log2 DATA_W)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
div_start  input  1  EX holds a DIV/DIVU this cycle (level, held while stalled)
div_signed  input  1  1 = DIV, 0 = DIVU; sampled with div_start
div_annul  input  1  EX instruction flushed (exception/branch flush); abort divide
opa  input  DATA_W  dividend (rs value after forwarding)
opb  input  DATA_W  divisor (rt value after forwarding)
div_stall  output  1  to hazard unit; pipeline held while 1
result_valid  output  1  one-cycle pulse: hi/lo valid, write HI/LO
hi  output  DATA_W  remainder
lo  output  DATA_W  quotient

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, internal regs=0.
  - Outputs at reset: div_stall=0, result_valid=0, hi=0, lo=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_start=1 and div_annul=0: latch |opa|, |opb| (absolute values only when div_signed=1), sign of quotient (opa[31]^opb[31]) and sign of dividend. Counter=0. Go BUSY.
  - opb=0: go straight to DONE. lo=32'hFFFF_FFFF, hi=opa (raw, no sign fixup).
- div_stall = (IDLE & div_start & ~div_annul) | (BUSY & ~div_annul). Combinational, so the requesting instruction never leaves EX in its first cycle.
- BUSY:
  - Each cycle: shift partial remainder left by 1, bringing in the next dividend MSB.
  - Trial-subtract divisor (DATA_W+1-bit subtract). If non-negative, keep the difference and shift 1 into the quotient; else shift 0.
  - Counter increments; after iteration counter==DATA_W-1, go DONE.
  - BUSY lasts exactly DATA_W cycles.
- DONE (one cycle):
  - div_stall=0, result_valid=1.
  - Signed: lo negated if quotient sign=1; hi negated if dividend sign=1.
  - Next state IDLE unconditionally.
  - div_start is ignored in DONE; it is still high from the same instruction, which advances at the end of this cycle.
- Latency: first div_start cycle = T0. BUSY T1..T32, DONE T33. div_stall high T0..T32 (33 cycles).
- hi/lo are registered and hold their last value outside DONE; consumers qualify with result_valid.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0 (natural two's-complement wrap, no trap).
- Annul:
  - div_annul=1 in IDLE: no start.
  - div_annul=1 in BUSY: div_stall drops the same cycle, next state IDLE, no result_valid, hi/lo unchanged.
  - div_annul=1 in DONE: result_valid forced to 0.
- Reset mid-operation: immediate return to IDLE with reset values; no pulse after release.
- Back-to-back divides: the second div_start seen in IDLE the cycle after DONE starts a fresh operation. Minimum spacing DONE→T0 = 1 cycle.
- Only opa/opb sampled in IDLE are used; operand changes during BUSY are ignored.

Test Plan:
- DIVU opa=100, opb=7 → stall high exactly 33 cycles; DONE: lo=14, hi=2, result_valid 1 cycle.
- DIV opa=-7 (0xFFFF_FFF9), opb=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). Repeat with opb=-2 → lo=3, hi=-1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0. DIVU 0xFFFF_FFFF/1 → lo=0xFFFF_FFFF, hi=0.
- opb=0, opa=0x1234 → one stall cycle, next cycle DONE: lo=0xFFFF_FFFF, hi=0x1234.
- Start DIVU 50/5, assert div_annul at BUSY cycle 10 → div_stall 0 that cycle, no result_valid ever, next div_start 9/4 yields lo=2, hi=1 after 33 stall cycles.
- resetn pulsed low at BUSY cycle 20 → all outputs 0 asynchronously; after release with div_start=0, no result_valid and div_stall=0.
